// File: rtl/pc_fetch_sequencer_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter fetch sequencer.
//   - default datapath width and the reset / interrupt vectors
//   - default fetch watchdog timeout
//   - state encoding of the sequencer FSM
package pc_seq_pkg;

   localparam int          WIDTH_DEF        = 16;
   localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;
   localparam logic [15:0] IRQ_VECTOR_DEF   = 16'hFFF0;
   localparam int          TIMEOUT_DEF      = 15;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_FAULT = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_FETCH = ST_FETCH,
      S_EXEC  = ST_EXEC,
      S_FAULT = ST_FAULT
   } state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: bundles the instruction-memory read handshake and the
// execute-stage handshake of the fetch sequencer.
//   master : sequencer side (drives MEM_REQ/MEM_ADDR, IR/IR_VALID, PC, EPC,
//            IRQ_ACK, FAULT; receives RUN, MEM_ACK/MEM_DATA, EXEC_DONE,
//            BR_TAKEN/BR_TARGET, IRQ)
//   slave  : memory / execute-stage side, directions reversed
interface pc_fetch_sequencer_if
   #(parameter int WIDTH = pc_seq_pkg::WIDTH_DEF);

   logic             RUN;
   logic             MEM_REQ;
   logic [WIDTH-1:0] MEM_ADDR;
   logic             MEM_ACK;
   logic [WIDTH-1:0] MEM_DATA;
   logic [WIDTH-1:0] IR;
   logic             IR_VALID;
   logic             EXEC_DONE;
   logic             BR_TAKEN;
   logic [WIDTH-1:0] BR_TARGET;
   logic             IRQ;
   logic             IRQ_ACK;
   logic [WIDTH-1:0] EPC;
   logic [WIDTH-1:0] PC;
   logic             FAULT;

   modport master (
      input  RUN, MEM_ACK, MEM_DATA, EXEC_DONE, BR_TAKEN, BR_TARGET, IRQ,
      output MEM_REQ, MEM_ADDR, IR, IR_VALID, IRQ_ACK, EPC, PC, FAULT
   );

   modport slave (
      output RUN, MEM_ACK, MEM_DATA, EXEC_DONE, BR_TAKEN, BR_TARGET, IRQ,
      input  MEM_REQ, MEM_ADDR, IR, IR_VALID, IRQ_ACK, EPC, PC, FAULT
   );

endinterface

// File: rtl/pc_fetch_sequencer_fetch_watchdog.sv
// fetch_watchdog: counts cycles a fetch waits for its memory acknowledge.
//   CLK, CLR : clock and asynchronous active-high reset
//   clr      : synchronous clear (has priority over en)
//   en       : count one waiting cycle
//   tc       : high when the current waiting cycle is the TIMEOUT-th one,
//              i.e. an unacknowledged edge now exhausts the budget
module fetch_watchdog
   #(parameter int TIMEOUT = pc_seq_pkg::TIMEOUT_DEF,
     parameter int CW      = 8)
   (input  logic CLK,
    input  logic CLR,
    input  logic clr,
    input  logic en,
    output logic tc);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en)
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign tc = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: sequences the program counter and the instruction-fetch
// handshake. Requests a read at PC, latches the returned word into IR, waits
// for the execute stage, then picks the next PC (increment, branch target or
// interrupt vector). A watchdog parks the block in a sticky fault state when
// a fetch is never acknowledged.
//   CLK  : rising-edge clock
//   CLR  : asynchronous active-high reset
//   bus  : memory and execute-stage handshake (master side)
// All outputs come straight from flops.
module pc_fetch_sequencer
   import pc_seq_pkg::*;
   #(parameter int               WIDTH        = WIDTH_DEF,
     parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
     parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'(IRQ_VECTOR_DEF),
     parameter int               TIMEOUT      = TIMEOUT_DEF)
   (input logic                CLK,
    input logic                CLR,
    pc_fetch_sequencer_if.master bus);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic             mem_req_q, mem_req_d;
   logic             ir_valid_q, ir_valid_d;
   logic             irq_ack_q, irq_ack_d;
   logic             fault_q, fault_d;
   logic [WIDTH-1:0] pc_sel;
   logic             wd_clr, wd_en, wd_tc;

   // The watchdog only runs while a fetch is outstanding and unacknowledged.
   assign wd_clr = (state_q != S_FETCH) || bus.MEM_ACK;
   assign wd_en  = !wd_clr;

   fetch_watchdog #(.TIMEOUT(TIMEOUT), .CW(8)) u_watchdog (
      .CLK (CLK),
      .CLR (CLR),
      .clr (wd_clr),
      .en  (wd_en),
      .tc  (wd_tc)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      epc_d      = epc_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = mem_req_q;
      ir_valid_d = 1'b0;
      irq_ack_d  = 1'b0;
      fault_d    = fault_q;
      pc_sel     = pc_q;

      case (state_q)
         S_IDLE: begin
            mem_req_d = 1'b0;
            if (bus.RUN) begin
               state_d    = S_FETCH;
               mem_req_d  = 1'b1;
               mem_addr_d = pc_q;
            end
         end

         S_FETCH: begin
            if (bus.MEM_ACK) begin
               ir_d       = bus.MEM_DATA;
               ir_valid_d = 1'b1;
               pc_d       = pc_q + WIDTH'(1);
               mem_req_d  = 1'b0;
               state_d    = S_EXEC;
            end else if (wd_tc) begin
               mem_req_d = 1'b0;
               fault_d   = 1'b1;
               state_d   = S_FAULT;
            end
         end

         S_EXEC: begin
            if (bus.EXEC_DONE) begin
               // PC already points past the current instruction, so it is
               // the return address unless a branch redirects it.
               if (bus.IRQ) begin
                  epc_d     = bus.BR_TAKEN ? bus.BR_TARGET : pc_q;
                  pc_sel    = IRQ_VECTOR;
                  irq_ack_d = 1'b1;
               end else if (bus.BR_TAKEN) begin
                  pc_sel = bus.BR_TARGET;
               end
               pc_d = pc_sel;
               if (bus.RUN) begin
                  state_d    = S_FETCH;
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_sel;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            mem_req_d = 1'b0;
            fault_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_VECTOR;
         ir_q       <= '0;
         epc_q      <= '0;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         ir_valid_q <= 1'b0;
         irq_ack_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         epc_q      <= epc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         ir_valid_q <= ir_valid_d;
         irq_ack_q  <= irq_ack_d;
         fault_q    <= fault_d;
      end
   end

   assign bus.MEM_REQ  = mem_req_q;
   assign bus.MEM_ADDR = mem_addr_q;
   assign bus.IR       = ir_q;
   assign bus.IR_VALID = ir_valid_q;
   assign bus.IRQ_ACK  = irq_ack_q;
   assign bus.EPC      = epc_q;
   assign bus.PC       = pc_q;
   assign bus.FAULT    = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: acts as instruction memory and execute stage,
// and tracks expected PC / IR / EPC at instruction level.
module tb_pc_fetch_sequencer;

   localparam int          TIMEOUT = 15;
   localparam logic [15:0] IRQ_V   = 16'hFFF0;

   logic CLK = 1'b0;
   logic CLR = 1'b1;

   pc_fetch_sequencer_if #(.WIDTH(16)) bus ();

   pc_fetch_sequencer #(
      .WIDTH        (16),
      .RESET_VECTOR (16'h0000),
      .IRQ_VECTOR   (IRQ_V),
      .TIMEOUT      (TIMEOUT)
   ) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;
   int n_instr  = 0;

   logic [15:0] exp_pc, exp_ir, exp_epc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.RUN       = 1'b0;
      bus.MEM_ACK   = 1'b0;
      bus.MEM_DATA  = '0;
      bus.EXEC_DONE = 1'b0;
      bus.BR_TAKEN  = 1'b0;
      bus.BR_TARGET = '0;
      bus.IRQ       = 1'b0;
   endtask

   task automatic do_reset();
      CLR = 1'b1;
      clear_inputs();
      step();
      step();
      check("rst_pc", bus.PC, 16'h0000);
      check("rst_ir", bus.IR, 16'h0000);
      check("rst_epc", bus.EPC, 16'h0000);
      check("rst_addr", bus.MEM_ADDR, 16'h0000);
      check("rst_flags", {bus.MEM_REQ, bus.IR_VALID, bus.IRQ_ACK, bus.FAULT}, 4'b0000);
      CLR    = 1'b0;
      exp_pc  = 16'h0000;
      exp_ir  = 16'h0000;
      exp_epc = 16'h0000;
   endtask

   // Start from IDLE: raise RUN and expect a request at the current PC.
   task automatic start_run();
      bus.RUN = 1'b1;
      step();
      check("start_req", bus.MEM_REQ, 1'b1);
      check("start_addr", bus.MEM_ADDR, exp_pc);
   endtask

   // One whole instruction. Entry: DUT is fetching (MEM_REQ=1).
   // w = unacknowledged fetch cycles, e = EXEC cycles before EXEC_DONE.
   task automatic do_instr(input int w, input logic [15:0] d, input int e,
                           input logic br, input logic [15:0] tgt,
                           input logic irq, input logic run_after);
      logic [15:0] addr;
      bit          exp_ack;
      addr = exp_pc;
      check("fetch_addr", bus.MEM_ADDR, exp_pc);
      bus.RUN = run_after;
      for (int i = 0; i < w; i++) begin
         bus.MEM_ACK   = 1'b0;
         bus.EXEC_DONE = 1'($urandom);
         bus.BR_TAKEN  = 1'($urandom);
         bus.BR_TARGET = 16'($urandom);
         bus.IRQ       = 1'($urandom);
         step();
         check("fetch_hold", {bus.MEM_REQ, bus.FAULT, bus.MEM_ADDR}, {2'b10, addr});
      end
      bus.MEM_ACK  = 1'b1;
      bus.MEM_DATA = d;
      step();
      bus.MEM_ACK = 1'b0;
      exp_ir = d;
      exp_pc = exp_pc + 16'd1;
      check("ack_ir", bus.IR, exp_ir);
      check("ack_irv", bus.IR_VALID, 1'b1);
      check("ack_pc", bus.PC, exp_pc);
      check("ack_req_irqack", {bus.MEM_REQ, bus.IRQ_ACK}, 2'b00);
      for (int i = 0; i < e; i++) begin
         bus.EXEC_DONE = 1'b0;
         bus.MEM_ACK   = 1'($urandom);
         bus.MEM_DATA  = 16'($urandom);
         bus.IRQ       = 1'($urandom);
         step();
         check("exec_wait", {bus.IR_VALID, bus.MEM_REQ, bus.IR, bus.PC}, {2'b00, exp_ir, exp_pc});
      end
      bus.MEM_ACK   = 1'b0;
      bus.EXEC_DONE = 1'b1;
      bus.BR_TAKEN  = br;
      bus.BR_TARGET = tgt;
      bus.IRQ       = irq;
      step();
      bus.EXEC_DONE = 1'b0;
      bus.BR_TAKEN  = 1'b0;
      exp_ack = irq;
      if (irq) begin
         exp_epc = br ? tgt : exp_pc;
         exp_pc  = IRQ_V;
      end else if (br) begin
         exp_pc = tgt;
      end
      check("done_pc", bus.PC, exp_pc);
      check("done_epc", bus.EPC, exp_epc);
      check("done_irqack", bus.IRQ_ACK, exp_ack);
      check("done_irv", bus.IR_VALID, 1'b0);
      check("done_req", bus.MEM_REQ, run_after);
      $display("instr %0d addr=%h ir=%h br=%0d irq=%0d run=%0d -> pc=%h epc=%h",
               n_instr, addr, d, br, irq, run_after, bus.PC, bus.EPC);
      n_instr++;
      if (!run_after) begin
         for (int i = 0; i < 3; i++) begin
            bus.MEM_ACK = 1'($urandom);
            bus.IRQ     = 1'($urandom);
            step();
            check("idle_quiet", {bus.MEM_REQ, bus.IRQ_ACK, bus.IR_VALID, bus.PC}, {3'b000, exp_pc});
         end
         bus.MEM_ACK = 1'b0;
         start_run();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      clear_inputs();
      do_reset();

      // Basic fetch with two wait cycles, then wrap and branch cases.
      start_run();
      do_instr(2, 16'h1234, 0, 1'b0, 16'h0000, 1'b0, 1'b1);
      do_instr(0, 16'h5555, 1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
      do_instr(0, 16'h0F0F, 0, 1'b0, 16'h0000, 1'b0, 1'b1);
      check("wrap_addr", bus.MEM_ADDR, 16'h0000);
      do_instr(1, 16'h2222, 0, 1'b1, 16'habcd, 1'b0, 1'b1);
      do_instr(0, 16'h3333, 2, 1'b1, 16'habcd, 1'b1, 1'b1);
      check("irq_epc", bus.EPC, 16'habcd);
      // Ack on the last cycle the watchdog allows.
      do_instr(TIMEOUT - 1, 16'h7777, 0, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Randomised instruction stream.
      for (int k = 0; k < 40; k++) begin
         do_instr(int'($urandom_range(0, TIMEOUT - 1)), 16'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
      end

      // RUN dropped while fetching.
      do_instr(3, 16'h4444, 1, 1'b0, 16'h0000, 1'b0, 1'b0);

      // Asynchronous reset in the middle of EXEC with PC=107f.
      do_instr(0, 16'h1111, 0, 1'b1, 16'h107e, 1'b0, 1'b1);
      bus.MEM_ACK  = 1'b1;
      bus.MEM_DATA = 16'h9999;
      step();
      bus.MEM_ACK = 1'b0;
      check("pre_clr_pc", bus.PC, 16'h107f);
      step();
      #2;
      CLR = 1'b1;
      #1;
      check("aclr_pc", bus.PC, 16'h0000);
      check("aclr_ir", bus.IR, 16'h0000);
      check("aclr_flags", {bus.MEM_REQ, bus.IR_VALID, bus.IRQ_ACK, bus.FAULT}, 4'b0000);
      $display("async clear during exec -> pc=%h", bus.PC);
      step();
      do_reset();

      // Fetch that is never acknowledged.
      start_run();
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         step();
         check("wd_nofault", {bus.FAULT, bus.MEM_REQ}, 2'b01);
      end
      step();
      check("wd_fault", {bus.FAULT, bus.MEM_REQ}, 2'b10);
      $display("timeout fetch addr=%h -> fault=%0d", bus.MEM_ADDR, bus.FAULT);
      for (int i = 0; i < 8; i++) begin
         bus.RUN       = 1'($urandom);
         bus.MEM_ACK   = 1'($urandom);
         bus.EXEC_DONE = 1'($urandom);
         step();
         check("fault_sticky", {bus.FAULT, bus.MEM_REQ, bus.IR_VALID, bus.PC}, {3'b100, 16'h0000});
      end
      do_reset();
      check("fault_cleared", bus.FAULT, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
